mem_access: RTL
===============

# mem_access

Memory-access pipeline stage between the EX/MEM register and the MEM/WB register. Non-memory instructions pass through to the MEM/WB interface in the same cycle. Loads and stores run a single-outstanding request/acknowledge transaction on the data bus. While a transaction is in flight, the stage holds the upstream pipeline with `stallreq` and presents a bubble to MEM/WB.

## Interface
Parameters: none. Widths come from the shared defines: RegBus is 32, RegAddrBus is 5.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_waddr` in 5: destination register.
- `ex_wreg` in 1: register-write enable.
- `ex_wdata` in 32: ALU result; used as write data for non-load instructions.
- `ex_memop` in 4: memory operation code, `mem_op_e` from the package (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW).
- `ex_mem_addr` in 32: effective byte address.
- `ex_store_data` in 32: rt value for stores.
- `dbus_req` out 1: bus request; held high until `dbus_ack`.
- `dbus_we` out 1: 1 for a store.
- `dbus_addr` out 32: word-aligned address (bits [1:0] = 0).
- `dbus_sel` out 4: byte-lane enables.
- `dbus_wdata` out 32: store data, replicated across lanes.
- `dbus_rdata` in 32: load data; sampled only in the cycle `dbus_ack` is high.
- `dbus_ack` in 1: one-cycle completion pulse.
- `mem_waddr` out 5: destination register to MEM/WB.
- `mem_wreg` out 1: register-write enable to MEM/WB.
- `mem_wdata` out 32: write data to MEM/WB.
- `stallreq` out 1: asks the pipeline controller to freeze the PC, IF/ID, ID/EX and EX/MEM.

## Operation
- The FSM has three states in `mem_state_e`: IDLE, BUSY and DONE.
- **IDLE, `ex_memop` = NONE:**
  - Combinational pass-through: `mem_*` = `ex_*`.
  - `stallreq` = 0.
- **IDLE, `ex_memop` ≠ NONE:**
  - `stallreq` = 1 combinationally.
  - Bubble to MEM/WB: `mem_wreg` = 0, `mem_waddr` = 0, `mem_wdata` = 0.
  - Register `dbus_addr`, `dbus_sel`, `dbus_wdata` and `dbus_we`; set `dbus_req` = 1; go to BUSY.
- **BUSY:**
  - `stallreq` = 1 and the bubble continues.
  - Bus outputs hold stable.
  - On `dbus_ack`: drop `dbus_req`, capture the aligned and extended load data into `ld_q`, go to DONE.
- **DONE:**
  - `stallreq` = 0.
  - `mem_waddr` = `ex_waddr`.
  - `mem_wreg` = `ex_wreg` for loads and 0 for stores.
  - `mem_wdata` = `ld_q` for loads.
  - Next state is always IDLE.
- **Byte lanes (big-endian):**
  - Byte: `addr[1:0]` = 00 selects `sel` 1000 and data [31:24]; 11 selects `sel` 0001 and data [7:0].
  - Halfword: `addr[1]` = 0 selects `sel` 1100; 1 selects `sel` 0011.
  - Word: `sel` 1111.
- **Store replication:** SB drives `{4{b}}`, SH drives `{2{h}}`, SW drives the word unchanged.
- **Load extension:** LB and LH sign-extend; LBU and LHU zero-extend.
- **Ignored and undefined inputs:**
  - `dbus_ack` is ignored in IDLE and DONE.
  - `ex_*` are stable while `stallreq` = 1, because the controller guarantees it.
  - An undefined `ex_memop` encoding is treated as NONE.

## Timing
- **Reset values:** asynchronous reset forces IDLE and sets `dbus_req`, `dbus_we`, `dbus_sel`, `dbus_addr`, `dbus_wdata` and `ld_q` to 0. All `mem_*` outputs and `stallreq` then follow the IDLE rules.
- **Reset mid-transaction:** `dbus_req` falls immediately, the transaction is abandoned, and a late `dbus_ack` is ignored.
- **Latency, non-memory op:** 0 cycles through this stage.
- **Latency, memory op:** the op is presented in cycle T and `dbus_req` rises at T+1. With an ack at T+1+k, the result is valid in DONE at T+2+k. MEM/WB captures it on that edge and the pipeline resumes.
- **Minimum stall:** 2 cycles when k = 0.
- **Back-to-back ops:** each memory op returns to IDLE before the next is examined. Two loads therefore cost at least 3 cycles each.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Misaligned LH/LHU/SH (`addr[0]` = 1) and misaligned LW/SW (`addr[1:0]` ≠ 0) issue no bus request.
  - The stage goes straight to DONE with `mem_wreg` = 0.
  - A registered output `mem_excp_align` (1 bit) pulses high in that DONE cycle. The port exists only in this build.
- `MEM_ALIGN_CHECK_EN` undefined: the low address bits that the lane logic does not use are ignored, and the access proceeds as aligned.

## Structure
- **Package `mem_pkg`:**
  - `mem_op_e` (4-bit enum) and `mem_state_e`.
  - Lane-select constants `SEL_B0`…`SEL_W`.
- **Sub-module `mem_lane_align`** (purely combinational): takes the op, `addr[1:0]`, store data and `rdata`. It produces `sel`, replicated `wdata`, the extended load data and the misalignment flag.

## Test plan
- **Pass-through:** NONE op with `ex_waddr` = 5'd3, `ex_wreg` = 1, `ex_wdata` = 32'h1234_5678 → same-cycle `mem_*` equal the inputs, `stallreq` = 0, `dbus_req` stays 0.
- **LW, zero wait:** addr 0x100, ack in the first BUSY cycle with rdata 0xDEADBEEF → `dbus_sel` = 1111, `stallreq` high for 2 cycles, DONE drives `mem_wdata` = 0xDEADBEEF.
- **LB vs LBU:** addr 0x103, rdata 0x000000F0 → LB gives 0xFFFFFFF0, LBU gives 0x000000F0, `sel` = 0001.
- **SH with 3 wait cycles:** addr 0x202, data 0x0000ABCD → `dbus_we` = 1, `sel` = 0011, `wdata` = 0xABCDABCD, `stallreq` held 5 cycles, `mem_wreg` = 0 throughout.
- **Reset in BUSY:** `rst` asserted → `dbus_req` drops with no clock edge; an ack arriving 1 cycle after reset release leaves the FSM in IDLE.
- **Misaligned LW at 0x101, `MEM_ALIGN_CHECK_EN` defined:** no `dbus_req`, `mem_excp_align` pulses once, `mem_wreg` = 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-access stage.
//   mem_op_e     - 4-bit memory operation code carried in EX/MEM
//   mem_state_e  - mem_access FSM states
//   SEL_*        - big-endian byte-lane enable patterns
//   is_mem_op / is_load / is_store - opcode classification helpers
package mem_pkg;

    localparam int unsigned REG_W   = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SEL_BW  = 4;

    typedef enum logic [OP_W-1:0] {
        NONE = 4'd0,
        LB   = 4'd1,
        LBU  = 4'd2,
        LH   = 4'd3,
        LHU  = 4'd4,
        LW   = 4'd5,
        SB   = 4'd6,
        SH   = 4'd7,
        SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    // Lane 0 is the most significant byte (big-endian)
    localparam logic [SEL_BW-1:0] SEL_NONE = 4'b0000;
    localparam logic [SEL_BW-1:0] SEL_B0   = 4'b1000;
    localparam logic [SEL_BW-1:0] SEL_B1   = 4'b0100;
    localparam logic [SEL_BW-1:0] SEL_B2   = 4'b0010;
    localparam logic [SEL_BW-1:0] SEL_B3   = 4'b0001;
    localparam logic [SEL_BW-1:0] SEL_H0   = 4'b1100;
    localparam logic [SEL_BW-1:0] SEL_H1   = 4'b0011;
    localparam logic [SEL_BW-1:0] SEL_W    = 4'b1111;

    // Undefined encodings fall through to 0, i.e. they behave as NONE
    function automatic logic is_load(input mem_op_e op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic is_mem_op(input mem_op_e op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the data bus.
//   op_i       - memory opcode (mem_op_e encoding)
//   addr_lo_i  - effective address bits [1:0]
//   sdata_i    - store data (rt)
//   rdata_i    - raw bus read data
//   sel_o      - byte-lane enables
//   wdata_o    - store data replicated across the selected lanes
//   ldata_o    - aligned and sign/zero-extended load data
//   misalign_o - access is not naturally aligned for its size
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [REG_W-1:0]  sdata_i,
    input  logic [REG_W-1:0]  rdata_i,
    output logic [SEL_BW-1:0] sel_o,
    output logic [REG_W-1:0]  wdata_o,
    output logic [REG_W-1:0]  ldata_o,
    output logic              misalign_o
);

    logic [SEL_BW-1:0] byte_sel;
    logic [7:0]        byte_v;
    logic [SEL_BW-1:0] half_sel;
    logic [15:0]       half_v;

    // Byte and halfword extraction for big-endian lanes
    always_comb begin
        byte_sel = SEL_B0;
        byte_v   = rdata_i[31:24];
        case (addr_lo_i)
            2'b00: begin byte_sel = SEL_B0; byte_v = rdata_i[31:24]; end
            2'b01: begin byte_sel = SEL_B1; byte_v = rdata_i[23:16]; end
            2'b10: begin byte_sel = SEL_B2; byte_v = rdata_i[15:8];  end
            default: begin byte_sel = SEL_B3; byte_v = rdata_i[7:0]; end
        endcase
        half_sel = addr_lo_i[1] ? SEL_H1 : SEL_H0;
        half_v   = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    // Per-opcode lane enables, store replication and load extension
    always_comb begin
        sel_o      = SEL_NONE;
        wdata_o    = '0;
        ldata_o    = '0;
        misalign_o = 1'b0;
        case (mem_op_e'(op_i))
            LB: begin
                sel_o   = byte_sel;
                ldata_o = {{24{byte_v[7]}}, byte_v};
            end
            LBU: begin
                sel_o   = byte_sel;
                ldata_o = {24'd0, byte_v};
            end
            LH: begin
                sel_o      = half_sel;
                ldata_o    = {{16{half_v[15]}}, half_v};
                misalign_o = addr_lo_i[0];
            end
            LHU: begin
                sel_o      = half_sel;
                ldata_o    = {16'd0, half_v};
                misalign_o = addr_lo_i[0];
            end
            LW: begin
                sel_o      = SEL_W;
                ldata_o    = rdata_i;
                misalign_o = |addr_lo_i;
            end
            SB: begin
                sel_o   = byte_sel;
                wdata_o = {4{sdata_i[7:0]}};
            end
            SH: begin
                sel_o      = half_sel;
                wdata_o    = {2{sdata_i[15:0]}};
                misalign_o = addr_lo_i[0];
            end
            SW: begin
                sel_o      = SEL_W;
                wdata_o    = sdata_i;
                misalign_o = |addr_lo_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage between EX/MEM and MEM/WB.
// Non-memory ops pass straight through; loads/stores run one
// request/ack transaction on the data bus while stalling upstream.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned accesses skip the
// bus, report via mem_excp_align and suppress the register write).
// Ports:
//   clk, rst                 - clock, async active-high reset
//   ex_*                     - EX/MEM register contents
//   dbus_req/we/addr/sel/wdata - registered data-bus request
//   dbus_rdata, dbus_ack     - data-bus response
//   mem_waddr/wreg/wdata     - to MEM/WB (combinational)
//   stallreq                 - freeze upstream pipeline (combinational)
//   mem_excp_align           - misalignment pulse (MEM_ALIGN_CHECK_EN only)
module mem_access
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [RADDR_W-1:0] ex_waddr,
    input  logic               ex_wreg,
    input  logic [REG_W-1:0]   ex_wdata,
    input  logic [OP_W-1:0]    ex_memop,
    input  logic [REG_W-1:0]   ex_mem_addr,
    input  logic [REG_W-1:0]   ex_store_data,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [REG_W-1:0]   dbus_addr,
    output logic [SEL_BW-1:0]  dbus_sel,
    output logic [REG_W-1:0]   dbus_wdata,
    input  logic [REG_W-1:0]   dbus_rdata,
    input  logic               dbus_ack,
    output logic [RADDR_W-1:0] mem_waddr,
    output logic               mem_wreg,
    output logic [REG_W-1:0]   mem_wdata,
    output logic               stallreq
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic               mem_excp_align
`endif
);

    mem_state_e        state_q;
    logic [REG_W-1:0]  ld_q;

    mem_op_e           op_c;
    logic              mem_op_c;
    logic              load_c;
    logic [SEL_BW-1:0] sel_c;
    logic [REG_W-1:0]  wdata_c;
    logic [REG_W-1:0]  ldata_c;
    logic              skip_c;
    logic              fault_c;

    assign op_c     = mem_op_e'(ex_memop);
    assign mem_op_c = is_mem_op(op_c);
    assign load_c   = is_load(op_c);

    // ex_* are held stable by the controller while stalled, so one
    // lane instance serves both request formation and load extension
    mem_lane_align u_lane (
        .op_i       (ex_memop),
        .addr_lo_i  (ex_mem_addr[1:0]),
        .sdata_i    (ex_store_data),
        .rdata_i    (dbus_rdata),
        .sel_o      (sel_c),
        .wdata_o    (wdata_c),
        .ldata_o    (ldata_c),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_o (skip_c)
`else
        .misalign_o ()
`endif
    );

`ifdef MEM_ALIGN_CHECK_EN
    // Pulse for exactly the DONE cycle reached via a misaligned access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_excp_align <= 1'b0;
        end else begin
            mem_excp_align <= (state_q == IDLE) && mem_op_c && skip_c;
        end
    end
    assign fault_c = mem_excp_align;
`else
    assign skip_c  = 1'b0;
    assign fault_c = 1'b0;
`endif

    // Transaction FSM with registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= SEL_NONE;
            dbus_wdata <= '0;
            ld_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op_c) begin
                        if (skip_c) begin
                            state_q <= DONE;
                        end else begin
                            dbus_req   <= 1'b1;
                            dbus_we    <= is_store(op_c);
                            dbus_addr  <= {ex_mem_addr[REG_W-1:2], 2'b00};
                            dbus_sel   <= sel_c;
                            dbus_wdata <= wdata_c;
                            state_q    <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        ld_q     <= ldata_c;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB drive and stall request
    always_comb begin
        stallreq  = 1'b0;
        mem_waddr = '0;
        mem_wreg  = 1'b0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    stallreq = 1'b1;
                end else begin
                    mem_waddr = ex_waddr;
                    mem_wreg  = ex_wreg;
                    mem_wdata = ex_wdata;
                end
            end
            BUSY: begin
                stallreq = 1'b1;
            end
            DONE: begin
                mem_waddr = ex_waddr;
                mem_wreg  = ex_wreg & load_c & ~fault_c;
                mem_wdata = load_c ? ld_q : '0;
            end
            default: ;
        endcase
    end

endmodule
